// File: rtl/mcu_dccm_sram_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mcu_dccm_sram_sink_ctrl
// Description : SRAM-side responder for the exported DCCM bank interface.
//               After reset, or on init_req, it sweeps every bank and writes
//               zero data with INIT_ECC. Core requests are blocked during the
//               sweep and flagged. Read data is held between reads.
// Revision    : 1.0 - initial release
// ============================================================================
module mcu_dccm_sram_sink_ctrl #(
  parameter int                NUM_BANKS = 4,
  parameter int                ADDR_W    = 11,
  parameter int                DATA_W    = 32,
  parameter int                ECC_W     = 7,
  parameter logic [ECC_W-1:0]  INIT_ECC  = '0
) (
  input  logic                          clk,
  input  logic                          rst_l,
  input  logic [NUM_BANKS-1:0]          dccm_clken,
  input  logic [NUM_BANKS-1:0]          dccm_wren_bank,
  input  logic [NUM_BANKS*ADDR_W-1:0]   dccm_addr_bank,
  input  logic [NUM_BANKS*DATA_W-1:0]   dccm_wr_data_bank,
  input  logic [NUM_BANKS*ECC_W-1:0]    dccm_wr_ecc_bank,
  output logic [NUM_BANKS*DATA_W-1:0]   dccm_bank_dout,
  output logic [NUM_BANKS*ECC_W-1:0]    dccm_bank_ecc,
  output logic [NUM_BANKS-1:0]          sram_cs,
  output logic [NUM_BANKS-1:0]          sram_we,
  output logic [NUM_BANKS*ADDR_W-1:0]   sram_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   sram_wdata,
  output logic [NUM_BANKS*ECC_W-1:0]    sram_wecc,
  input  logic [NUM_BANKS*DATA_W-1:0]   sram_rdata,
  input  logic [NUM_BANKS*ECC_W-1:0]    sram_recc,
  input  logic                          init_req,
  output logic                          init_busy,
  output logic                          init_done,
  output logic                          drop_err
);

  // Sweep terminates on the last word address; the counter then wraps to 0.
  localparam logic [ADDR_W-1:0] c_cnt_last = '1;

  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_cnt;
  logic                r_init_done;
  logic                r_drop_err;

  assign init_busy = (r_state == ST_INIT);
  assign init_done = r_init_done;
  assign drop_err  = r_drop_err;

  // Sweep sequencing, init handshake and sticky drop flag.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state     <= ST_INIT;
      r_cnt       <= '0;
      r_init_done <= 1'b0;
      r_drop_err  <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          // Core traffic is never forwarded while sweeping; record the loss.
          if (|dccm_clken) begin
            r_drop_err <= 1'b1;
          end
          if (r_cnt == c_cnt_last) begin
            r_cnt       <= '0;
            r_state     <= ST_READY;
            r_init_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_READY: begin
          // The request in this cycle is still forwarded; sweep starts next.
          if (init_req) begin
            r_state     <= ST_INIT;
            r_cnt       <= '0;
            r_init_done <= 1'b0;
            r_drop_err  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_INIT;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Macro request mux: sweep pattern in INIT, straight pass-through in READY.
  always_comb begin
    if (r_state == ST_INIT) begin
      sram_cs    = '1;
      sram_we    = '1;
      sram_addr  = {NUM_BANKS{r_cnt}};
      sram_wdata = '0;
      sram_wecc  = {NUM_BANKS{INIT_ECC}};
    end else begin
      sram_cs    = dccm_clken;
      sram_we    = dccm_wren_bank & dccm_clken;
      sram_addr  = dccm_addr_bank;
      sram_wdata = dccm_wr_data_bank;
      sram_wecc  = dccm_wr_ecc_bank;
    end
  end

  // Independent per-bank read return path with a hold register.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic              r_rd_pending;
    logic [DATA_W-1:0] r_dout_hold;
    logic [ECC_W-1:0]  r_ecc_hold;

    // Track a read issued last cycle and latch its returned data.
    always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
        r_rd_pending <= 1'b0;
        r_dout_hold  <= '0;
        r_ecc_hold   <= '0;
      end else begin
        r_rd_pending <= sram_cs[b] & ~sram_we[b];
        if (r_rd_pending) begin
          r_dout_hold <= sram_rdata[b*DATA_W +: DATA_W];
          r_ecc_hold  <= sram_recc[b*ECC_W +: ECC_W];
        end
      end
    end

    assign dccm_bank_dout[b*DATA_W +: DATA_W] =
      r_rd_pending ? sram_rdata[b*DATA_W +: DATA_W] : r_dout_hold;
    assign dccm_bank_ecc[b*ECC_W +: ECC_W] =
      r_rd_pending ? sram_recc[b*ECC_W +: ECC_W] : r_ecc_hold;
  end : g_bank

endmodule : mcu_dccm_sram_sink_ctrl
`default_nettype wire

// File: tb/tb_mcu_dccm_sram_sink_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mcu_dccm_sram_sink_ctrl
// Description : Directed self-checking bench for mcu_dccm_sram_sink_ctrl with
//               a behavioural synchronous SRAM macro per bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mcu_dccm_sram_sink_ctrl;

  localparam int NB    = 4;
  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 7;
  localparam int DEPTH = 16;

  logic                clk = 1'b0;
  logic                rst_l;
  logic [NB-1:0]       dccm_clken;
  logic [NB-1:0]       dccm_wren_bank;
  logic [NB*AW-1:0]    dccm_addr_bank;
  logic [NB*DW-1:0]    dccm_wr_data_bank;
  logic [NB*EW-1:0]    dccm_wr_ecc_bank;
  logic [NB*DW-1:0]    dccm_bank_dout;
  logic [NB*EW-1:0]    dccm_bank_ecc;
  logic [NB-1:0]       sram_cs;
  logic [NB-1:0]       sram_we;
  logic [NB*AW-1:0]    sram_addr;
  logic [NB*DW-1:0]    sram_wdata;
  logic [NB*EW-1:0]    sram_wecc;
  logic [NB*DW-1:0]    sram_rdata;
  logic [NB*EW-1:0]    sram_recc;
  logic                init_req;
  logic                init_busy;
  logic                init_done;
  logic                drop_err;

  int n_checks = 0;
  int n_fail   = 0;

  mcu_dccm_sram_sink_ctrl #(
    .NUM_BANKS (NB),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .ECC_W     (EW),
    .INIT_ECC  (7'h00)
  ) u_dut (
    .clk               (clk),
    .rst_l             (rst_l),
    .dccm_clken        (dccm_clken),
    .dccm_wren_bank    (dccm_wren_bank),
    .dccm_addr_bank    (dccm_addr_bank),
    .dccm_wr_data_bank (dccm_wr_data_bank),
    .dccm_wr_ecc_bank  (dccm_wr_ecc_bank),
    .dccm_bank_dout    (dccm_bank_dout),
    .dccm_bank_ecc     (dccm_bank_ecc),
    .sram_cs           (sram_cs),
    .sram_we           (sram_we),
    .sram_addr         (sram_addr),
    .sram_wdata        (sram_wdata),
    .sram_wecc         (sram_wecc),
    .sram_rdata        (sram_rdata),
    .sram_recc         (sram_recc),
    .init_req          (init_req),
    .init_busy         (init_busy),
    .init_done         (init_done),
    .drop_err          (drop_err)
  );

  always #5 clk = ~clk;

  // Behavioural SRAM macros: write on cs&we, registered read on cs&!we.
  logic [DW-1:0] mem_d [NB][DEPTH];
  logic [EW-1:0] mem_e [NB][DEPTH];

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (sram_cs[b]) begin
        if (sram_we[b]) begin
          mem_d[b][sram_addr[b*AW +: AW]] <= sram_wdata[b*DW +: DW];
          mem_e[b][sram_addr[b*AW +: AW]] <= sram_wecc[b*EW +: EW];
        end else begin
          sram_rdata[b*DW +: DW] <= mem_d[b][sram_addr[b*AW +: AW]];
          sram_recc[b*EW +: EW]  <= mem_e[b][sram_addr[b*AW +: AW]];
        end
      end
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dccm_clken        = '0;
    dccm_wren_bank    = '0;
    dccm_addr_bank    = '0;
    dccm_wr_data_bank = '0;
    dccm_wr_ecc_bank  = '0;
    init_req          = 1'b0;
  endtask

  task automatic set_bank(input int b, input logic en, input logic we,
                          input logic [AW-1:0] a, input logic [DW-1:0] d,
                          input logic [EW-1:0] e);
    dccm_clken[b]                = en;
    dccm_wren_bank[b]            = we;
    dccm_addr_bank[b*AW +: AW]   = a;
    dccm_wr_data_bank[b*DW +: DW] = d;
    dccm_wr_ecc_bank[b*EW +: EW] = e;
  endtask

  // Walks one full sweep starting at the current cycle (cnt expected 0).
  // drop_at / req_at inject a core read or an init_req at that sweep index.
  task automatic sweep_check(input int drop_at, input int req_at);
    logic [AW-1:0] ka;
    for (int k = 0; k < DEPTH; k++) begin
      idle();
      if (k == drop_at) set_bank(0, 1'b1, 1'b0, 4'd3, 32'h0, 7'h0);
      if (k == req_at)  init_req = 1'b1;
      #4;
      ka = k[AW-1:0];
      check_eq("sweep_cs",    sram_cs,    4'hF);
      check_eq("sweep_we",    sram_we,    4'hF);
      check_eq("sweep_addr",  sram_addr,  {NB{ka}});
      check_eq("sweep_wdata", sram_wdata, '0);
      check_eq("sweep_wecc",  sram_wecc,  '0);
      check_eq("sweep_busy",  init_busy,  1'b1);
      check_eq("sweep_done",  init_done,  1'b0);
      step();
    end
    idle();
    #4;
    check_eq("ready_done", init_done, 1'b1);
    check_eq("ready_busy", init_busy, 1'b0);
    step();
  endtask

  initial begin
    rst_l = 1'b0;
    idle();
    #2;
    check_eq("rst_busy", init_busy, 1'b1);
    check_eq("rst_done", init_done, 1'b0);
    check_eq("rst_drop", drop_err, 1'b0);
    check_eq("rst_dout", dccm_bank_dout, '0);
    check_eq("rst_ecc",  dccm_bank_ecc, '0);

    // Initial sweep with a blocked core read at index 3 and an ignored init_req.
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    sweep_check(3, 5);
    check_eq("drop_set", drop_err, 1'b1);

    // Write then read bank2 addr 5.
    idle();
    set_bank(2, 1'b1, 1'b1, 4'd5, 32'hDEADBEEF, 7'h2A);
    #4;
    check_eq("wr_cs",    sram_cs, 4'b0100);
    check_eq("wr_we",    sram_we, 4'b0100);
    check_eq("wr_addr",  sram_addr[8 +: 4], 4'd5);
    check_eq("wr_wdata", sram_wdata[64 +: 32], 32'hDEADBEEF);
    check_eq("wr_wecc",  sram_wecc[14 +: 7], 7'h2A);
    step();
    idle();
    set_bank(2, 1'b1, 1'b0, 4'd5, 32'h0, 7'h0);
    #4;
    check_eq("rd_cs", sram_cs, 4'b0100);
    check_eq("rd_we", sram_we, 4'b0000);
    step();
    idle();
    #4;
    check_eq("rd_dout2", dccm_bank_dout[64 +: 32], 32'hDEADBEEF);
    check_eq("rd_ecc2",  dccm_bank_ecc[14 +: 7], 7'h2A);
    step();
    repeat (10) step();
    #4;
    check_eq("hold_dout2", dccm_bank_dout[64 +: 32], 32'hDEADBEEF);
    check_eq("hold_ecc2",  dccm_bank_ecc[14 +: 7], 7'h2A);
    check_eq("drop_sticky", drop_err, 1'b1);
    step();

    // Distinct writes to all banks, then simultaneous reads.
    idle();
    set_bank(0, 1'b1, 1'b1, 4'd1, 32'h11111111, 7'h01);
    set_bank(1, 1'b1, 1'b1, 4'd2, 32'h22222222, 7'h02);
    set_bank(2, 1'b1, 1'b1, 4'd4, 32'h44444444, 7'h04);
    set_bank(3, 1'b1, 1'b1, 4'd3, 32'h33333333, 7'h03);
    #4;
    check_eq("mwr_we", sram_we, 4'hF);
    step();
    idle();
    set_bank(0, 1'b1, 1'b0, 4'd1, 32'h0, 7'h0);
    set_bank(1, 1'b1, 1'b0, 4'd2, 32'h0, 7'h0);
    set_bank(2, 1'b1, 1'b0, 4'd4, 32'h0, 7'h0);
    set_bank(3, 1'b1, 1'b0, 4'd3, 32'h0, 7'h0);
    #4;
    check_eq("mrd_cs", sram_cs, 4'hF);
    check_eq("mrd_we", sram_we, 4'h0);
    step();
    idle();
    #4;
    check_eq("mrd_dout", dccm_bank_dout, {32'h33333333, 32'h44444444, 32'h22222222, 32'h11111111});
    check_eq("mrd_ecc",  dccm_bank_ecc,  {7'h03, 7'h04, 7'h02, 7'h01});
    step();

    // init_req together with a bank1 write: write forwarded, then sweep.
    idle();
    set_bank(1, 1'b1, 1'b1, 4'd6, 32'h12345678, 7'h11);
    init_req = 1'b1;
    #4;
    check_eq("req_cs",    sram_cs, 4'b0010);
    check_eq("req_we",    sram_we, 4'b0010);
    check_eq("req_addr",  sram_addr[4 +: 4], 4'd6);
    check_eq("req_wdata", sram_wdata[32 +: 32], 32'h12345678);
    check_eq("req_busy",  init_busy, 1'b0);
    step();
    check_eq("drop_clr", drop_err, 1'b0);
    sweep_check(-1, -1);
    check_eq("drop_clr_after", drop_err, 1'b0);
    idle();
    set_bank(1, 1'b1, 1'b0, 4'd6, 32'h0, 7'h0);
    step();
    idle();
    #4;
    check_eq("swept_dout1", dccm_bank_dout[32 +: 32], 32'h0);
    check_eq("swept_ecc1",  dccm_bank_ecc[7 +: 7], 7'h0);
    check_eq("held_dout0",  dccm_bank_dout[0 +: 32], 32'h11111111);
    step();

    // Reset in the middle of a sweep at cnt=7.
    idle();
    init_req = 1'b1;
    step();
    for (int k = 0; k < 7; k++) begin
      idle();
      if (k == 2) set_bank(0, 1'b1, 1'b0, 4'd0, 32'h0, 7'h0);
      step();
    end
    idle();
    #1;
    check_eq("mid_addr", sram_addr, {NB{4'd7}});
    check_eq("mid_drop", drop_err, 1'b1);
    #1;
    rst_l = 1'b0;
    #1;
    check_eq("arst_busy", init_busy, 1'b1);
    check_eq("arst_done", init_done, 1'b0);
    check_eq("arst_drop", drop_err, 1'b0);
    check_eq("arst_dout", dccm_bank_dout, '0);
    check_eq("arst_ecc",  dccm_bank_ecc, '0);
    check_eq("arst_addr", sram_addr, '0);
    @(posedge clk);
    #1;
    rst_l = 1'b1;
    sweep_check(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mcu_dccm_sram_sink_ctrl
`default_nettype wire
